fetch_ctrl: RTL and testbench

Instruction-fetch controller for the MIPS core. It owns the program counter and issues one word request at a time to instruction memory over a req/ack handshake. Returned words go into a 2-entry fetch buffer that feeds decode through a valid/ready interface. It also handles branch/jump redirects, including a redirect that arrives while a request is still outstanding.

---
 rtl/fetch_ctrl_if.sv | 26 ++
 rtl/fetch_ctrl.sv | 157 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus bundle: instruction-memory req/ack port, the
// decode-facing valid/ready port, the redirect input and the fault flag.
// master = fetch_ctrl side, slave = memory/decode/branch-unit side.
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_fault,
        input  imem_ack, imem_rdata, id_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_fault,
        output imem_ack, imem_rdata, id_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, keeps at most one word request
// outstanding to instruction memory, buffers returned words in a 2-entry
// FIFO feeding decode, and handles redirects (including one that lands while
// a request is still outstanding, which is drained and discarded in FLUSH).
// Optional feature macro: FETCH_MISALIGN_CHECK_EN -- a misaligned redirect
// target raises a sticky fetch_fault and halts fetching until reset.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [1:0]  cnt_q, cnt_d;
    // Entry 0 is always the head; entry 1 shifts down on pop.
    logic [31:0] pc0_q, pc1_q, ins0_q, ins1_q;

    logic        req;
    logic        push, pop, flush;
    logic        halt;
    logic [1:0]  cnt_after_pop;
    logic [31:0] redir_tgt;

    // The stored PC is always word-aligned, so imem_addr[1:0] stay zero.
    assign redir_tgt = {bus.redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q;
    logic misalign;

    assign misalign = bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);
    assign halt     = fault_q | misalign;

    // Sticky fault: once set only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (misalign) begin
            fault_q <= 1'b1;
        end
    end

    assign bus.fetch_fault = fault_q;
`else
    logic [1:0] unused_redirect_lsb;

    assign unused_redirect_lsb = bus.redirect_pc[1:0];
    assign halt                = 1'b0;
    assign bus.fetch_fault     = 1'b0;
`endif

    assign pop           = (cnt_q != 2'd0) & bus.id_ready;
    assign cnt_after_pop = cnt_q - {1'b0, pop};

    // Next-state, PC/target update and FIFO push/flush decisions.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        req     = 1'b0;
        push    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.redirect_valid) begin
                    pc_d  = redir_tgt;
                    flush = 1'b1;
                end else if (!halt && cnt_after_pop != 2'd2) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                req = 1'b1;
                if (bus.imem_ack && bus.redirect_valid) begin
                    // Returned word is wrong-path: drop it and refetch now.
                    flush   = 1'b1;
                    pc_d    = redir_tgt;
                    state_d = halt ? IDLE : REQ;
                end else if (bus.imem_ack) begin
                    push    = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    // Only keep requesting if the FIFO still has room after this push.
                    state_d = (cnt_after_pop == 2'd0) ? REQ : IDLE;
                end else if (bus.redirect_valid) begin
                    // Request still in flight: hold its address until it is acked.
                    flush   = 1'b1;
                    tgt_d   = redir_tgt;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                req = 1'b1;
                if (bus.redirect_valid) begin
                    flush = 1'b1;
                    tgt_d = redir_tgt;
                end
                if (bus.imem_ack) begin
                    pc_d    = bus.redirect_valid ? redir_tgt : tgt_q;
                    state_d = halt ? IDLE : REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cnt_d = flush ? 2'd0 : (cnt_q + {1'b0, push} - {1'b0, pop});

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            tgt_q   <= RESET_PC;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    // FIFO storage: pop shifts entry 1 down, push lands in the first free slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc0_q  <= 32'd0;
            pc1_q  <= 32'd0;
            ins0_q <= 32'd0;
            ins1_q <= 32'd0;
        end else if (!flush) begin
            if (pop) begin
                pc0_q  <= pc1_q;
                ins0_q <= ins1_q;
            end
            if (push) begin
                if (cnt_after_pop == 2'd0) begin
                    pc0_q  <= pc_q;
                    ins0_q <= bus.imem_rdata;
                end else begin
                    pc1_q  <= pc_q;
                    ins1_q <= bus.imem_rdata;
                end
            end
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = (cnt_q != 2'd0);
    assign bus.if_instr  = ins0_q;
    assign bus.if_pc     = pc0_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl. A memory/branch driver issues randomized
// acks, id_ready and redirects; a fetch-stream model turns accepted memory
// transfers into expected {pc, instr} entries; a monitor pops and compares
// every instruction decode consumes.
`timescale 1ns/1ps
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_ctrl_if bus();

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        exp_q[$];
    int          n_checks  = 0;
    int          n_fail    = 0;
    int          delivered = 0;

    // Stimulus knobs, written by the sequencer and read by the driver.
    int          lat_fix    = 0;
    int          lat_max    = 3;
    int          rdy_pct    = 100;
    int          redir_pct  = 0;
    int          force_mode = 0;   // 1: redirect while waiting, 2: redirect with ack
    logic [31:0] force_tgt  = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic int next_lat();
        return (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, lat_max));
    endfunction

    // Driver: memory with variable latency, random decode stall, redirects.
    initial begin
        int          wait_cnt;
        logic        ack;
        logic        redir;
        logic [31:0] tgt;
        wait_cnt = 0;
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = 32'd0;
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        forever begin
            @(negedge clk);
            ack   = 1'b0;
            redir = 1'b0;
            tgt   = 32'($urandom_range(0, 1023));
`ifdef FETCH_MISALIGN_CHECK_EN
            tgt[1:0] = 2'b00;
`endif
            if (!rst) begin
                if (bus.imem_req) begin
                    if (wait_cnt <= 0) begin
                        ack      = 1'b1;
                        wait_cnt = next_lat();
                    end else begin
                        wait_cnt--;
                    end
                end
                if (force_mode == 1 && bus.imem_req && !ack) begin
                    redir = 1'b1; tgt = force_tgt; force_mode = 0;
                end else if (force_mode == 2 && ack) begin
                    redir = 1'b1; tgt = force_tgt; force_mode = 0;
                end else if (force_mode == 0 && int'($urandom_range(0, 99)) < redir_pct) begin
                    redir = 1'b1;
                end
            end
            bus.imem_ack       = ack;
            bus.imem_rdata     = ack ? mem_word(bus.imem_addr) : $urandom;
            bus.id_ready       = !rst && (int'($urandom_range(0, 99)) < rdy_pct);
            bus.redirect_valid = redir;
            bus.redirect_pc    = redir ? tgt : $urandom;
        end
    end

    // Fetch-stream model: what decode must eventually see, in order.
    initial begin
        logic [31:0] exp_pc, stale_addr, prev_addr;
        logic        stale, halted, prev_wait;
        exp_pc = 32'd0; stale = 1'b0; halted = 1'b0; prev_wait = 1'b0;
        stale_addr = 32'd0; prev_addr = 32'd0;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                exp_q.delete();
                exp_pc = 32'd0; stale = 1'b0; halted = 1'b0; prev_wait = 1'b0;
                continue;
            end
            if (prev_wait) check("addr_hold", bus.imem_addr, prev_addr);
            check("addr_aligned", {30'd0, bus.imem_addr[1:0]}, 32'd0);
            if (bus.imem_ack) begin
                if (stale) begin
                    check("stale_addr", bus.imem_addr, stale_addr);
                    stale = 1'b0;
                end else begin
                    if (halted) check("req_after_fault", {31'd0, bus.imem_req}, 32'd0);
                    check("req_addr", bus.imem_addr, exp_pc);
                    if (!bus.redirect_valid) begin
                        exp_q.push_back('{pc: exp_pc, instr: mem_word(exp_pc)});
                        exp_pc = exp_pc + 32'd4;
                    end
                end
            end
            if (bus.redirect_valid) begin
                exp_q.delete();
                if (bus.imem_req && !bus.imem_ack) begin
                    stale      = 1'b1;
                    stale_addr = bus.imem_addr;
                end
`ifdef FETCH_MISALIGN_CHECK_EN
                if (bus.redirect_pc[1:0] != 2'b00) halted = 1'b1;
`endif
                exp_pc = {bus.redirect_pc[31:2], 2'b00};
            end
            check("fifo_depth", {31'd0, exp_q.size() > 2}, 32'd0);
            prev_wait = bus.imem_req && !bus.imem_ack;
            prev_addr = bus.imem_addr;
        end
    end

    // Monitor: compare each consumed instruction against the scoreboard.
    initial begin
        logic        prev_redir, prev_stall;
        logic [31:0] stall_pc, stall_ins;
        ent_t        e;
        prev_redir = 1'b0; prev_stall = 1'b0; stall_pc = 32'd0; stall_ins = 32'd0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_redir = 1'b0; prev_stall = 1'b0;
                continue;
            end
            if (prev_redir) check("valid_after_redirect", {31'd0, bus.if_valid}, 32'd0);
            if (prev_stall && !prev_redir) begin
                check("hold_pc", bus.if_pc, stall_pc);
                check("hold_instr", bus.if_instr, stall_ins);
            end
            if (bus.if_valid && bus.id_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL deliver: got pc %h, required no instruction (scoreboard empty)", bus.if_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("if_pc", bus.if_pc, e.pc);
                    check("if_instr", bus.if_instr, e.instr);
                    delivered++;
                end
            end
            prev_redir = bus.redirect_valid;
            prev_stall = bus.if_valid && !bus.id_ready;
            stall_pc   = bus.if_pc;
            stall_ins  = bus.if_instr;
        end
    end

    task automatic wait_fire(input string name);
        int n;
        n = 0;
        while (force_mode != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (force_mode != 0) begin
            n_fail++;
            $display("FAIL %s: forced redirect issued=0 after %0d cycles, required 1", name, n);
            force_mode = 0;
        end
    endtask

    // Sequencer.
    initial begin
        int d0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_addr", bus.imem_addr, 32'd0);
        check("rst_valid", {31'd0, bus.if_valid}, 32'd0);
        check("rst_instr", bus.if_instr, 32'd0);
        check("rst_pc", bus.if_pc, 32'd0);
        check("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);
        #3 rst = 1'b0;

        // Zero-wait memory, decode always ready.
        @(negedge clk); #1;
        check("first_req", {31'd0, bus.imem_req}, 32'd1);
        check("first_addr", bus.imem_addr, 32'd0);
        @(negedge clk); #1;
        check("first_valid", {31'd0, bus.if_valid}, 32'd1);
        check("first_if_pc", bus.if_pc, 32'd0);
        d0 = delivered;
        repeat (20) @(negedge clk);
        check("throughput", 32'(delivered - d0), 32'd20);

        // Decode stall: FIFO fills and requests stop.
        rdy_pct = 0;
        repeat (6) @(negedge clk);
        #1;
        check("stall_req_low", {31'd0, bus.imem_req}, 32'd0);
        check("stall_valid", {31'd0, bus.if_valid}, 32'd1);
        rdy_pct = 100;
        repeat (10) @(negedge clk);

        // Slow memory.
        lat_fix = 2;
        repeat (20) @(negedge clk);

        // Redirect while a request is outstanding.
        force_tgt = 32'h0000_0100; force_mode = 1;
        wait_fire("redir_outstanding");
        repeat (12) @(negedge clk);

        // Redirect in the same cycle as an ack.
        lat_fix = 0;
        force_tgt = 32'h0000_0200; force_mode = 2;
        wait_fire("redir_with_ack");
        repeat (10) @(negedge clk);

        // PC wrap from the top of the address space.
        force_tgt = 32'hFFFF_FFF4; force_mode = 2;
        wait_fire("redir_wrap");
        repeat (10) @(negedge clk);

        // Randomized traffic.
        lat_fix = -1; lat_max = 3; rdy_pct = 70; redir_pct = 4;
        repeat (1500) @(negedge clk);

        // Reset mid-operation.
        #4 rst = 1'b1;
        @(negedge clk); #1;
        check("midrst_req", {31'd0, bus.imem_req}, 32'd0);
        check("midrst_valid", {31'd0, bus.if_valid}, 32'd0);
        #3 rst = 1'b0;
        repeat (300) @(negedge clk);
        check("progress", {31'd0, delivered > 500}, 32'd1);

        // Misaligned redirect target.
        redir_pct = 0; rdy_pct = 100; lat_fix = 0;
        force_tgt = 32'h0000_0102; force_mode = 2;
        wait_fire("redir_misaligned");
        @(negedge clk); #1;
`ifdef FETCH_MISALIGN_CHECK_EN
        check("fault_set", {31'd0, bus.fetch_fault}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            check("fault_no_req", {31'd0, bus.imem_req}, 32'd0);
        end
`else
        check("fault_tied", {31'd0, bus.fetch_fault}, 32'd0);
        check("misalign_addr", bus.imem_addr, 32'h0000_0100);
        repeat (10) @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
